// File: rtl/multicycle_control_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : multicycle_control_if                              |
// | Description : Control bundle between the multicycle control FSM  |
// |               and the 16-bit datapath.                           |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
interface multicycle_control_if;
   logic [3:0] Opcode;
   logic       Zero;
   logic       PCWrite;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic       MemToReg;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUCtl;
   logic [1:0] PCSource;
   logic [3:0] State;
   logic       Halted;

   // Control FSM side
   modport master (
      input  Opcode, Zero,
      output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemToReg,
             ALUSrcA, ALUSrcB, ALUCtl, PCSource, State, Halted
   );

   // Datapath side
   modport slave (
      output Opcode, Zero,
      input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemToReg,
             ALUSrcA, ALUSrcB, ALUCtl, PCSource, State, Halted
   );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : multicycle_control                                 |
// | Description : Moore-style control FSM for the 16-bit multicycle  |
// |               datapath (fetch/decode/execute/memory/write-back). |
// |               Optional macro HALT_OPCODE_EN enables opcode F as  |
// |               a halt instruction with a sticky HALT state.       |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module multicycle_control (
   input  wire logic            CLK,
   input  wire logic            CLR,
   multicycle_control_if.master bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADDR  = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXEC     = 4'd6,
      RWB      = 4'd7,
      IEXEC    = 4'd8,
      IWB      = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11,
      HALT     = 4'd12
   } state_t;

   localparam logic [3:0] c_OP_LW  = 4'd5;
   localparam logic [3:0] c_OP_SW  = 4'd6;
   localparam logic [3:0] c_OP_BEQ = 4'd7;

   state_t     r_state;
   state_t     w_next;

   logic       w_pcwrite;
   logic       w_iord;
   logic       w_memread;
   logic       w_memwrite;
   logic       w_irwrite;
   logic       w_regwrite;
   logic       w_memtoreg;
   logic       w_alusrca;
   logic [1:0] w_alusrcb;
   logic [2:0] w_aluctl;
   logic [1:0] w_pcsource;
`ifdef HALT_OPCODE_EN
   logic       w_halted;
`endif

   // State register; CLR returns the machine to FETCH.
   always_ff @(posedge CLK) begin
      if (CLR)
         r_state <= FETCH;
      else
         r_state <= w_next;
   end

   // Next-state and per-state control outputs (Zero only matters in BRANCH).
   always_comb begin
      w_next     = FETCH;
      w_pcwrite  = 1'b0;
      w_iord     = 1'b0;
      w_memread  = 1'b0;
      w_memwrite = 1'b0;
      w_irwrite  = 1'b0;
      w_regwrite = 1'b0;
      w_memtoreg = 1'b0;
      w_alusrca  = 1'b0;
      w_alusrcb  = 2'b00;
      w_aluctl   = 3'b000;
      w_pcsource = 2'b00;
`ifdef HALT_OPCODE_EN
      w_halted   = 1'b0;
`endif
      case (r_state)
         FETCH: begin
            w_memread = 1'b1;
            w_irwrite = 1'b1;
            w_pcwrite = 1'b1;
            w_alusrcb = 2'b01;
            w_next    = DECODE;
         end
         DECODE: begin
            // Branch target is precomputed here into ALUOut.
            w_alusrcb = 2'b11;
            case (bus.Opcode)
               4'd0, 4'd1, 4'd2, 4'd3: w_next = EXEC;
               4'd4:                   w_next = IEXEC;
               4'd5, 4'd6:             w_next = MEMADDR;
               4'd7, 4'd8:             w_next = BRANCH;
               4'd9:                   w_next = JUMP;
`ifdef HALT_OPCODE_EN
               4'd15:                  w_next = HALT;
`endif
               default:                w_next = FETCH;
            endcase
         end
         MEMADDR: begin
            w_alusrca = 1'b1;
            w_alusrcb = 2'b10;
            if (bus.Opcode == c_OP_LW)
               w_next = MEMREAD;
            else if (bus.Opcode == c_OP_SW)
               w_next = MEMWRITE;
            else
               w_next = FETCH;
         end
         MEMREAD: begin
            w_memread = 1'b1;
            w_iord    = 1'b1;
            w_next    = MEMWB;
         end
         MEMWB: begin
            w_regwrite = 1'b1;
            w_memtoreg = 1'b1;
         end
         MEMWRITE: begin
            w_memwrite = 1'b1;
            w_iord     = 1'b1;
         end
         EXEC: begin
            w_alusrca = 1'b1;
            w_aluctl  = {1'b0, bus.Opcode[1:0]};
            w_next    = RWB;
         end
         RWB: begin
            w_regwrite = 1'b1;
         end
         IEXEC: begin
            w_alusrca = 1'b1;
            w_alusrcb = 2'b10;
            w_next    = IWB;
         end
         IWB: begin
            w_regwrite = 1'b1;
         end
         BRANCH: begin
            w_alusrca  = 1'b1;
            w_aluctl   = 3'b001;
            w_pcsource = 2'b01;
            w_pcwrite  = (bus.Opcode == c_OP_BEQ) ? bus.Zero : ~bus.Zero;
         end
         JUMP: begin
            w_pcwrite  = 1'b1;
            w_pcsource = 2'b10;
         end
`ifdef HALT_OPCODE_EN
         HALT: begin
            w_halted = 1'b1;
            w_next   = HALT;
         end
`endif
         default: begin
            w_next = FETCH;
         end
      endcase
   end

   // Everything is held at zero while CLR is high so nothing is written.
   assign bus.PCWrite  = CLR ? 1'b0   : w_pcwrite;
   assign bus.IorD     = CLR ? 1'b0   : w_iord;
   assign bus.MemRead  = CLR ? 1'b0   : w_memread;
   assign bus.MemWrite = CLR ? 1'b0   : w_memwrite;
   assign bus.IRWrite  = CLR ? 1'b0   : w_irwrite;
   assign bus.RegWrite = CLR ? 1'b0   : w_regwrite;
   assign bus.MemToReg = CLR ? 1'b0   : w_memtoreg;
   assign bus.ALUSrcA  = CLR ? 1'b0   : w_alusrca;
   assign bus.ALUSrcB  = CLR ? 2'b00  : w_alusrcb;
   assign bus.ALUCtl   = CLR ? 3'b000 : w_aluctl;
   assign bus.PCSource = CLR ? 2'b00  : w_pcsource;
   assign bus.State    = CLR ? 4'd0   : r_state;
`ifdef HALT_OPCODE_EN
   assign bus.Halted   = CLR ? 1'b0   : w_halted;
`else
   assign bus.Halted   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_multicycle_control                              |
// | Description : Self-checking bench for multicycle_control: table  |
// |               of instructions, random instruction stream against |
// |               an instruction-level model, reset/halt/abort cases.|
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module tb_multicycle_control;

   logic CLK;
   logic CLR;

   multicycle_control_if bus ();

   multicycle_control dut (
      .CLK (CLK),
      .CLR (CLR),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Flattened view of all control outputs (State excluded).
   logic [15:0] act;
   assign act = {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                 bus.RegWrite, bus.MemToReg, bus.ALUSrcA, bus.ALUSrcB,
                 bus.ALUCtl, bus.PCSource, bus.Halted};

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] op;
      logic       zero;
      int         len;
      int         st[5];
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Control word the datapath should see in a given step.
   function automatic logic [15:0] exp_out(input int st, input logic [3:0] op, input logic zero);
      logic pcw, iord, mr, mw, irw, rw, m2r, sa, h;
      logic [1:0] sb, ps;
      logic [2:0] ac;
      {pcw, iord, mr, mw, irw, rw, m2r, sa, h} = '0;
      sb = 2'b00; ps = 2'b00; ac = 3'b000;
      case (st)
         0:  begin pcw = 1; mr = 1; irw = 1; sb = 2'b01; end
         1:  sb = 2'b11;
         2:  begin sa = 1; sb = 2'b10; end
         3:  begin mr = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mw = 1; iord = 1; end
         6:  begin sa = 1; ac = {1'b0, op[1:0]}; end
         7:  rw = 1;
         8:  begin sa = 1; sb = 2'b10; end
         9:  rw = 1;
         10: begin sa = 1; ac = 3'b001; ps = 2'b01; pcw = (op == 4'd7) ? zero : !zero; end
         11: begin pcw = 1; ps = 2'b10; end
`ifdef HALT_OPCODE_EN
         12: h = 1;
`endif
         default: ;
      endcase
      return {pcw, iord, mr, mw, irw, rw, m2r, sa, sb, ac, ps, h};
   endfunction

   // Instruction-level model: which steps an opcode walks through.
   function automatic vec_t model_plan(input logic [3:0] op, input logic zero);
      vec_t v;
      v.op = op; v.zero = zero;
      v.st = '{0, 1, 0, 0, 0};
      if (op <= 4'd3)                    begin v.len = 4; v.st[2] = 6;  v.st[3] = 7; end
      else if (op == 4'd4)               begin v.len = 4; v.st[2] = 8;  v.st[3] = 9; end
      else if (op == 4'd5)               begin v.len = 5; v.st[2] = 2;  v.st[3] = 3; v.st[4] = 4; end
      else if (op == 4'd6)               begin v.len = 4; v.st[2] = 2;  v.st[3] = 5; end
      else if (op == 4'd7 || op == 4'd8) begin v.len = 3; v.st[2] = 10; end
      else if (op == 4'd9)               begin v.len = 3; v.st[2] = 11; end
      else                               v.len = 2;
      return v;
   endfunction

   task automatic add(input logic [3:0] op, input logic zero, input int len,
                      input int s0, input int s1, input int s2, input int s3, input int s4);
      vec_t v;
      v.op = op; v.zero = zero; v.len = len;
      v.st = '{s0, s1, s2, s3, s4};
      tbl.push_back(v);
   endtask

   // Starts in a FETCH cycle, ends in the next FETCH cycle.
   task automatic run_vec(input vec_t v, input string tag);
      int s;
      bus.Opcode = v.op;
      bus.Zero   = v.zero;
      for (int i = 0; i < v.len; i++) begin
         s = v.st[i];
         // Opcode is ignored in write-back/jump steps; scramble it there.
         if (i == v.len - 1 && (s == 4 || s == 5 || s == 7 || s == 9 || s == 11)) begin
            bus.Opcode = 4'($urandom);
            #1;
         end
         chk({tag, "_state"}, 32'(bus.State), 32'(s));
         chk({tag, "_outs"},  32'(act), 32'(exp_out(s, v.op, v.zero)));
         @(posedge CLK); #1;
      end
      chk({tag, "_return_fetch"}, 32'(bus.State), 32'd0);
   endtask

   logic lw_watch = 1'b0;
   logic rw_seen  = 1'b0;
   always @(posedge CLK) if (lw_watch && bus.RegWrite) rw_seen <= 1'b1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      logic [3:0] rop;

      // Hand-written expectations: opcode, Zero, length, step states.
      add(4'h0, 1'b0, 4, 0, 1, 6, 7, 0);
      add(4'h1, 1'b0, 4, 0, 1, 6, 7, 0);
      add(4'h2, 1'b1, 4, 0, 1, 6, 7, 0);
      add(4'h3, 1'b0, 4, 0, 1, 6, 7, 0);
      add(4'h4, 1'b0, 4, 0, 1, 8, 9, 0);
      add(4'h5, 1'b0, 5, 0, 1, 2, 3, 4);
      add(4'h6, 1'b0, 4, 0, 1, 2, 5, 0);
      add(4'h7, 1'b1, 3, 0, 1, 10, 0, 0);
      add(4'h8, 1'b1, 3, 0, 1, 10, 0, 0);
      add(4'h7, 1'b0, 3, 0, 1, 10, 0, 0);
      add(4'h8, 1'b0, 3, 0, 1, 10, 0, 0);
      add(4'h9, 1'b0, 3, 0, 1, 11, 0, 0);
      add(4'hA, 1'b0, 2, 0, 1, 0, 0, 0);
      add(4'hE, 1'b1, 2, 0, 1, 0, 0, 0);
`ifndef HALT_OPCODE_EN
      add(4'hF, 1'b0, 2, 0, 1, 0, 0, 0);
`endif

      // Reset: outputs and State forced low while CLR is high.
      CLR = 1'b1; bus.Opcode = 4'h0; bus.Zero = 1'b0;
      #1;
      chk("reset_t0_outs", 32'(act), 32'd0);
      chk("reset_t0_state", 32'(bus.State), 32'd0);
      repeat (3) begin
         @(posedge CLK); #1;
         chk("reset_outs", 32'(act), 32'd0);
         chk("reset_state", 32'(bus.State), 32'd0);
      end
      CLR = 1'b0;
      #1;
      chk("post_reset_state", 32'(bus.State), 32'd0);
      chk("post_reset_fetch_strobes", {29'd0, bus.MemRead, bus.IRWrite, bus.PCWrite}, 32'b111);

      // Table-driven instructions.
      foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d_op%0h", i, tbl[i].op));

      // Random instruction stream checked against the model.
      for (int n = 0; n < 60; n++) begin
         rop = 4'($urandom_range(0, 15));
`ifdef HALT_OPCODE_EN
         if (rop == 4'hF) rop = 4'h1;
`endif
         v = model_plan(rop, 1'($urandom));
         run_vec(v, $sformatf("rnd%0d_op%0h", n, rop));
      end

      // CLR during MEMREAD of lw abandons it without any register write.
      lw_watch = 1'b1;
      bus.Opcode = 4'h5; bus.Zero = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
      end
      chk("abort_in_memread", 32'(bus.State), 32'd3);
      CLR = 1'b1;
      #1;
      chk("abort_outs_same_cycle", 32'(act), 32'd0);
      @(posedge CLK); #1;
      chk("abort_outs_next", 32'(act), 32'd0);
      chk("abort_state_next", 32'(bus.State), 32'd0);
      CLR = 1'b0;
      #1;
      chk("abort_fetch_state", 32'(bus.State), 32'd0);
      chk("abort_fetch_outs", 32'(act), 32'(exp_out(0, 4'h5, 1'b0)));
      @(posedge CLK); #1;
      chk("abort_no_regwrite", 32'(rw_seen), 32'd0);
      lw_watch = 1'b0;
      // Finish this fresh lw normally to land back in FETCH.
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1;
      end
      chk("after_abort_fetch", 32'(bus.State), 32'd0);

`ifdef HALT_OPCODE_EN
      // Halt: sticky HALT state until CLR.
      bus.Opcode = 4'hF;
      @(posedge CLK); #1;
      chk("halt_decode", 32'(bus.State), 32'd1);
      for (int i = 0; i < 12; i++) begin
         @(posedge CLK); #1;
         bus.Opcode = 4'($urandom);
         chk("halt_state", 32'(bus.State), 32'd12);
         chk("halt_outs", 32'(act), 32'(exp_out(12, 4'hF, 1'b0)));
      end
      CLR = 1'b1;
      #1;
      chk("halt_clr_outs", 32'(act), 32'd0);
      @(posedge CLK); #1;
      CLR = 1'b0;
      #1;
      chk("halt_exit_state", 32'(bus.State), 32'd0);
      chk("halt_exit_halted", 32'(bus.Halted), 32'd0);
`else
      // Without the halt feature opcode F is a two-cycle NOP.
      bus.Opcode = 4'hF;
      chk("nohalt_fetch_halted", 32'(bus.Halted), 32'd0);
      @(posedge CLK); #1;
      chk("nohalt_decode", 32'(bus.State), 32'd1);
      chk("nohalt_decode_halted", 32'(bus.Halted), 32'd0);
      @(posedge CLK); #1;
      chk("nohalt_back_fetch", 32'(bus.State), 32'd0);
      chk("nohalt_halted", 32'(bus.Halted), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM for the 16-bit multicycle datapath: the control-side counterpart of the datapath's IR/flag outputs. Each cycle it reads the opcode field IR[15:12] and the ALU zero flag, then drives every datapath enable and mux select through fetch, decode, execute, memory and write-back steps. It sits beside the datapath in the processor top level and replaces hand-driven control in benches.

## Interface
Parameters: none.

Ports:
- CLK  in  1  clock; all state changes on rising edge
- CLR  in  1  reset; synchronous, active-high
- Opcode  in  4  IR[15:12] from datapath; stable after FETCH
- Zero  in  1  ALU zero flag, valid in BRANCH state
- PCWrite  out  1  PC load enable
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load enable
- RegWrite  out  1  register file write enable
- MemToReg  out  1  write-back select: 0=ALUOut, 1=MDR
- ALUSrcA  out  1  0=PC, 1=A register
- ALUSrcB  out  2  00=B register, 01=constant 1, 10=sign-ext immediate, 11=sign-ext immediate (branch offset)
- ALUCtl  out  3  000 add, 001 sub, 010 and, 011 or
- PCSource  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
- State  out  4  current state encoding, debug
- Halted  out  1  high in HALT state

## Operation
- Opcodes: 0 add, 1 sub, 2 and, 3 or (R-type); 4 addi; 5 lw; 6 sw; 7 beq; 8 bne; 9 j; F halt (macro-gated); all others are illegal and execute as a NOP.
- State encodings: FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC=6, RWB=7, IEXEC=8, IWB=9, BRANCH=10, JUMP=11, HALT=12.
- Any output not listed for a state is 0.
- FETCH: MemRead, IRWrite, PCWrite, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSource=00. Next: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, add (precompute branch target).
  - Next by opcode: 0–3→EXEC; 4→IEXEC; 5,6→MEMADDR; 7,8→BRANCH; 9→JUMP; F→HALT; illegal→FETCH.
- MEMADDR: ALUSrcA=1, ALUSrcB=10, add. Next: lw→MEMREAD, sw→MEMWRITE.
- MEMREAD: MemRead, IorD=1. Next: MEMWB.
- MEMWB: RegWrite, MemToReg=1. Next: FETCH.
- MEMWRITE: MemWrite, IorD=1. Next: FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUCtl={0,Opcode[1:0]}. Next: RWB.
- RWB: RegWrite, MemToReg=0. Next: FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10, add. Next: IWB.
- IWB: RegWrite, MemToReg=0. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSource=01.
  - PCWrite = Zero for beq, ~Zero for bne (the only Mealy term).
  - Next: FETCH.
- JUMP: PCWrite, PCSource=10. Next: FETCH.
- HALT: all strobes 0, Halted=1. Stays in HALT until CLR.

## Timing
- Reset: CLR sampled at the rising edge sets the state to FETCH.
  - While CLR is high, all outputs are forced to 0 and State reads 0, so nothing is written during reset.
  - The first FETCH strobes appear in the first cycle after CLR falls.
- CLR asserted mid-instruction abandons it at the next edge; no partial write occurs after that edge.
- Outputs are combinational from the state register (plus Zero in BRANCH), valid the whole cycle, and sampled by the datapath at the next edge.
- Instruction latency in cycles:
  - R-type: 4
  - addi: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - j: 3
  - illegal: 2
  - halt: 2 cycles, then in HALT from the 3rd cycle.
- Opcode is sampled only in DECODE, MEMADDR, EXEC and BRANCH. Changes at other times are ignored.

## Configuration
- HALT_OPCODE_EN defined: opcode F transitions DECODE→HALT; Halted is driven from the state.
- HALT_OPCODE_EN undefined:
  - Opcode F is illegal (DECODE→FETCH).
  - State 12 is unreachable and Halted is tied to 0.
  - An unknown state encoding always recovers to FETCH on the next edge.

## Test plan
- CLR=1 for 3 edges, then 0 -> all outputs 0 during reset; State=0 with MemRead=IRWrite=PCWrite=1 in the first post-reset cycle.
- Opcode=1 (sub) -> State sequence 0,1,6,7,0; ALUCtl=001 in EXEC; RegWrite=1 only in RWB.
- Opcode=5 then Opcode=6 -> lw sequence 0,1,2,3,4 with MemToReg=1 in MEMWB; sw sequence 0,1,2,5 with MemWrite=1 and IorD=1 in MEMWRITE only.
- Opcode=7 with Zero=1, then Opcode=8 with Zero=1 -> PCWrite=1 in BRANCH for beq, 0 for bne; PCSource=01 in both.
- Opcode=F -> with macro, State=12 and Halted=1, persisting 10+ cycles until CLR; without macro, back to FETCH after 2 cycles with Halted=0.
- CLR asserted during MEMREAD of lw -> next cycle all outputs 0; no RegWrite pulse ever occurs for that lw.
